// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
// Holds the handshake FSM encoding, the default FIFO depth and a saturating increment helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } rxc_state_t;

  localparam int DEFAULT_DEPTH = 8;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: dout always presents the oldest stored entry.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];

  // Storage has no reset so it can map onto RAM; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receiver-side controller: handshakes bytes from a UART receiver into a FIFO,
// drops framing-error bytes and keeps saturating framing/overrun error counts.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   rx_ferr,
  input  logic                   rx_oerr,
  output logic                   rx_rdy,
  input  logic                   rd_en,
  output logic [7:0]             dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   clr_err,
  output logic [7:0]             ferr_cnt,
  output logic [7:0]             oerr_cnt
);

  rxc_state_t state_reg;
  rxc_state_t state_next;
  logic       rx_rdy_reg;
  logic       push;
  logic       ferr_inc;
  logic       oerr_inc;
  logic       oerr_reg;
  logic [7:0] ferr_cnt_reg;
  logic [7:0] oerr_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      rx_rdy_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rx_rdy_reg <= (state_next == ST_ACK);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        // A good byte waits while the FIFO is full; a bad byte is always taken so it can be dropped.
        if (rx_valid && (rx_ferr || !full)) begin
          state_next = ST_ACK;
        end
      end
      ST_ACK:      state_next = ST_WAIT_LOW;
      ST_WAIT_LOW: begin
        if (!rx_valid) begin
          state_next = ST_IDLE;
        end
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    push     = 1'b0;
    ferr_inc = 1'b0;
    if (state_reg == ST_IDLE && rx_valid) begin
      push     = !rx_ferr && !full;
      ferr_inc = rx_ferr;
    end
  end

  assign oerr_inc = rx_oerr && !oerr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      oerr_reg     <= 1'b0;
      ferr_cnt_reg <= 8'd0;
      oerr_cnt_reg <= 8'd0;
    end else begin
      oerr_reg <= rx_oerr;
      if (clr_err) begin
        ferr_cnt_reg <= 8'd0;
        oerr_cnt_reg <= 8'd0;
      end else begin
        if (ferr_inc) begin
          ferr_cnt_reg <= sat_inc8(ferr_cnt_reg);
        end
        if (oerr_inc) begin
          oerr_cnt_reg <= sat_inc8(oerr_cnt_reg);
        end
      end
    end
  end

  assign rx_rdy   = rx_rdy_reg;
  assign ferr_cnt = ferr_cnt_reg;
  assign oerr_cnt = oerr_cnt_reg;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rx_data),
    .pop   (rd_en),
    .dout  (dout),
    .empty (empty),
    .full  (full),
    .count (count)
  );

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 8, meaning FIFO depth in bytes (power of two, 2..64).
REQ-002 The block SHALL expose port clk  input  1  system clock; all logic rising-edge.
REQ-003 The block SHALL expose port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL expose port rx_valid  input  1  receiver byte-available flag.
REQ-005 The block SHALL expose port rx_data  input  8  receiver byte.
REQ-006 The block SHALL expose port rx_ferr  input  1  receiver framing error, qualified by rx_valid.
REQ-007 The block SHALL expose port rx_oerr  input  1  receiver overrun flag, level.
REQ-008 The block SHALL expose port rx_rdy  output  1  acknowledge pulse to receiver.
REQ-009 The block SHALL expose port rd_en  input  1  consumer pop request.
REQ-010 The block SHALL expose port dout  output  8  FIFO head byte (show-ahead).
REQ-011 The block SHALL expose port empty, full  output  1 each  FIFO status.
REQ-012 The block SHALL expose port count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-013 The block SHALL expose port clr_err  input  1  synchronous clear of error counters.
REQ-014 The block SHALL expose port ferr_cnt, oerr_cnt  output  8 each  saturating error counts.

Function
REQ-015 The handshake FSM SHALL have states IDLE, ACK, WAIT_LOW.
REQ-016 In IDLE, rx_valid=1 with (rx_ferr=1 or full=0) SHALL move the FSM to ACK on the next edge.
REQ-017 On the IDLE->ACK edge, a good byte (rx_ferr=0) SHALL be pushed; a framing-error byte SHALL be discarded and ferr_cnt incremented.
REQ-018 rx_rdy SHALL be registered and high exactly one cycle, in ACK; ACK SHALL always move to WAIT_LOW.
REQ-019 WAIT_LOW SHALL return to IDLE on the first cycle rx_valid=0, guaranteeing one push per byte.
REQ-020 In IDLE with rx_valid=1, rx_ferr=0 and full=1, the FSM SHALL stay in IDLE with rx_rdy=0 (backpressure; receiver overruns).
REQ-021 oerr_cnt SHALL increment once per rising edge of rx_oerr, detected by a registered copy.
REQ-022 Both counters SHALL saturate at 255; clr_err SHALL zero both and take priority over a same-cycle increment.
REQ-023 rd_en with empty=0 SHALL pop one byte; rd_en with empty=1 SHALL be ignored.
REQ-024 dout SHALL equal the oldest stored byte whenever empty=0; when empty=1 it is don't-care.
REQ-025 A same-cycle push and pop SHALL leave count unchanged and preserve order.
REQ-026 A push SHALL become visible on dout/empty/count the cycle after the IDLE->ACK edge.
REQ-027 Pointers SHALL wrap modulo DEPTH; full SHALL be count==DEPTH and empty SHALL be count==0.
REQ-028 A pop from a full FIFO SHALL allow a stalled IDLE byte to be accepted on the following edge.

Reset
REQ-029 rst SHALL force FSM=IDLE, rx_rdy=0, count=0, empty=1, full=0, ferr_cnt=0, oerr_cnt=0, and clear the rx_oerr edge register.
REQ-030 rst asserted mid-handshake SHALL abandon the byte with no push; FIFO contents SHALL be discarded.

Structure
REQ-031 A shared package uart_pkg SHALL hold the FSM state enum (rxc_state_t) and the default DEPTH constant.
REQ-032 Storage SHALL be a single sub-module sync_fifo (show-ahead, parameter DEPTH, WIDTH=8); FSM and counters SHALL stay in uart_rx_ctrl.

Verification
REQ-033 Reset, then rx_valid=1 with rx_data=0x5A and rx_ferr=0 held until rx_rdy -> rx_rdy pulses one cycle; the next cycle empty=0, dout=0x5A, count=1.
REQ-034 rx_valid=1 with rx_ferr=1 and rx_data=0xFF -> rx_rdy pulses, FIFO stays empty, ferr_cnt=1.
REQ-035 Push 8 bytes 0x01..0x08 with DEPTH=8, then offer 0x09 -> full=1 and rx_rdy stays 0; one rd_en returns 0x01, then 0x09 is accepted and the later order is 0x02..0x09.
REQ-036 Toggle rx_oerr high three separate times while holding it high 10 cycles each -> oerr_cnt=3; 300 ferr bytes -> ferr_cnt=255; clr_err -> both counters 0.
REQ-037 Assert rst during ACK with count=3 -> the next cycle count=0, empty=1, rx_rdy=0, FSM=IDLE.
REQ-038 Hold rx_valid=1 for 5 cycles after rx_rdy -> exactly one push occurs.
